// File: rtl/dsp_pipe_ce_ctrl_if.sv
// Valid/ready handshake bundle between the DSP pipe controller,
// its upstream operand source and its downstream result sink.
interface dsp_pipe_ce_ctrl_if;
  logic s_valid;
  logic s_ready;
  logic m_valid;
  logic m_ready;

  modport master (
    output s_valid,
    input  s_ready,
    input  m_valid,
    output m_ready
  );

  modport slave (
    input  s_valid,
    output s_ready,
    output m_valid,
    input  m_ready
  );
endinterface

// File: rtl/dsp_pipe_ce_ctrl.sv
// Clock-enable controller for the DSP pipeline registers.
// Optional stall counter: define DSP_PIPE_STALL_CNT_EN.
module dsp_pipe_ce_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int OCC_W      = 5
) (
  input  logic                  CLK,
  input  logic                  rst_a,
  dsp_pipe_ce_ctrl_if.slave     hs,
  output logic [NUM_STAGES-1:0] ce,
  input  logic                  flush,
  input  logic                  drain,
  output logic                  drain_done,
  output logic [OCC_W-1:0]      occupancy,
  output logic                  busy,
  output logic [15:0]           stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_STAGES-1:0] r_v;
  logic [NUM_STAGES-1:0] w_chain;
  logic [OCC_W-1:0]      r_occ;
  logic [OCC_W-1:0]      w_occ_nxt;
  logic                  r_done;
  logic                  w_acc_en;
  logic                  w_acc;
  logic                  w_out;

  // enable ripples back from the output: a stage moves if it is
  // empty or the stage after it moves, which collapses bubbles
  always_comb begin
    w_chain = '0;
    w_chain[NUM_STAGES-1] = !r_v[NUM_STAGES-1] | hs.m_ready;
    for (int k = NUM_STAGES-2; k >= 0; k--) begin
      w_chain[k] = !r_v[k] | w_chain[k+1];
    end
  end

  // flush freezes every stage; drain/done block new operands
  assign ce       = flush ? '0 : w_chain;
  assign w_acc_en = !flush & !drain &
                    ((r_state == IDLE) | (r_state == RUN));
  assign hs.s_ready = ce[0] & w_acc_en;
  assign hs.m_valid = r_v[NUM_STAGES-1];
  assign w_acc      = hs.s_valid & hs.s_ready;
  assign w_out      = hs.m_valid & hs.m_ready;

  // stage valid bits advance under their own enable
  always_ff @(posedge CLK or posedge rst_a) begin
    if (rst_a) begin
      r_v <= '0;
    end else if (flush) begin
      r_v <= '0;
    end else begin
      if (ce[0]) r_v[0] <= w_acc;
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (ce[k]) r_v[k] <= r_v[k-1];
      end
    end
  end

  // occupancy tracks accepts minus consumed results
  always_comb begin
    w_occ_nxt = r_occ;
    if (flush) begin
      w_occ_nxt = '0;
    end else if (w_acc & !w_out) begin
      w_occ_nxt = r_occ + OCC_W'(1);
    end else if (!w_acc & w_out) begin
      w_occ_nxt = r_occ - OCC_W'(1);
    end
  end

  // occupancy register
  always_ff @(posedge CLK or posedge rst_a) begin
    if (rst_a) r_occ <= '0;
    else       r_occ <= w_occ_nxt;
  end

  // control FSM next state; flush abandons any drain
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (drain)
            w_state_nxt = (w_occ_nxt == '0) ? DONE : DRAIN;
          else if (w_acc)
            w_state_nxt = RUN;
        end
        RUN: begin
          if (drain)
            w_state_nxt = (w_occ_nxt == '0) ? DONE : DRAIN;
          else if (w_occ_nxt == '0)
            w_state_nxt = IDLE;
        end
        DRAIN: begin
          if (w_occ_nxt == '0) w_state_nxt = DONE;
        end
        DONE: begin
          if (!drain) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // state register; done pulses only on entry into DONE,
  // so holding drain high in DONE gives no repeat pulse
  always_ff @(posedge CLK or posedge rst_a) begin
    if (rst_a) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == DONE) & (r_state != DONE);
    end
  end

  assign drain_done = r_done;
  assign occupancy  = r_occ;
  assign busy       = (r_occ != '0) | (r_state != IDLE);

`ifdef DSP_PIPE_STALL_CNT_EN
  logic [15:0] r_stall;

  // count cycles a result waits on downstream, saturating
  always_ff @(posedge CLK or posedge rst_a) begin
    if (rst_a) begin
      r_stall <= '0;
    end else if (flush) begin
      r_stall <= '0;
    end else if (hs.m_valid & !hs.m_ready &
                 (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cnt = r_stall;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
